// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle add/sub/and/or, 32-cycle shift-add multiply.
// A multiply holds the block busy and ignores new issues until its result is out.
`timescale 1ns/1ps
module iter_alu #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic [2:0]        ALUCtrl_i,
    output logic [DATA_W-1:0] data_o,
    output logic              zero_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] mcand_r;
    logic [DATA_W-1:0] mplier_r;
    logic [DATA_W-1:0] acc_r;
    logic [4:0]        count_r;
    logic [DATA_W-1:0] data_r;
    logic              zero_r;
    logic              valid_r;
    logic              err_r;

    logic [DATA_W-1:0] single_res_s;
    logic              illegal_s;
    logic [DATA_W-1:0] acc_next_s;

    // Single-cycle result and illegal-code detection for the op on the inputs.
    always_comb begin
        single_res_s = {DATA_W{1'b0}};
        illegal_s    = 1'b0;
        case (ALUCtrl_i)
            OP_ADD:  single_res_s = data1_i + data2_i;
            OP_SUB:  single_res_s = data1_i - data2_i;
            OP_AND:  single_res_s = data1_i & data2_i;
            OP_OR:   single_res_s = data1_i | data2_i;
            OP_MUL:  single_res_s = {DATA_W{1'b0}};
            default: begin
                single_res_s = {DATA_W{1'b0}};
                illegal_s    = 1'b1;
            end
        endcase
    end

    // One shift-add step; bits shifted out of the multiplicand cannot affect the low word.
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Control FSM, multiply datapath and registered result outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r  <= IDLE;
            mcand_r  <= {DATA_W{1'b0}};
            mplier_r <= {DATA_W{1'b0}};
            acc_r    <= {DATA_W{1'b0}};
            count_r  <= 5'd0;
            data_r   <= {DATA_W{1'b0}};
            zero_r   <= 1'b0;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (valid_i) begin
                        if (ALUCtrl_i == OP_MUL) begin
                            mcand_r  <= data1_i;
                            mplier_r <= data2_i;
                            acc_r    <= {DATA_W{1'b0}};
                            count_r  <= 5'd0;
                            state_r  <= MUL;
                        end else begin
                            data_r  <= single_res_s;
                            zero_r  <= (single_res_s == {DATA_W{1'b0}});
                            err_r   <= illegal_s;
                            valid_r <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    count_r  <= count_r + 5'd1;
                    // Fixed 32 steps: no early exit even when the multiplier runs out of ones.
                    if (count_r == 5'd31) begin
                        data_r  <= acc_next_s;
                        zero_r  <= (acc_next_s == {DATA_W{1'b0}});
                        err_r   <= 1'b0;
                        valid_r <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign data_o  = data_r;
    assign zero_o  = zero_r;
    assign valid_o = valid_r;
    assign err_o   = err_r;
    assign busy_o  = (state_r == MUL);

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: scoreboard of expected {err, zero, data}
// pushed at issue and popped when valid_o is observed.
`timescale 1ns/1ps
module tb_iter_alu;

    logic        clk;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [2:0]  ALUCtrl_i;
    logic [31:0] data_o;
    logic        zero_o;
    logic        valid_o;
    logic        busy_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [33:0] exp_q[$];

    iter_alu #(.DATA_W(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .data1_i  (data1_i),
        .data2_i  (data2_i),
        .ALUCtrl_i(ALUCtrl_i),
        .data_o   (data_o),
        .zero_o   (zero_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o),
        .err_o    (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [33:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        e;
        e = 1'b0;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a * b;
            default: begin r = 32'd0; e = 1'b1; end
        endcase
        return {e, (r == 32'd0), r};
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_i   = v;
        ALUCtrl_i = op;
        data1_i   = a;
        data2_i   = b;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(1'b1, op, a, b);
        exp_q.push_back(model(op, a, b));
    endtask

    task automatic test_reset();
        logic [33:0] e;
        rst_i = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        n_tests++;
        if ({data_o, zero_o, valid_o, busy_o, err_o} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_state: got data=%h zero=%b valid=%b busy=%b err=%b, expected all 0",
                     data_o, zero_o, valid_o, busy_o, err_o);
        end
        rst_i = 1'b1;
        issue(3'd0, 32'd2, 32'd3);
        @(negedge clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        e = exp_q.pop_front();
        n_tests++;
        if (valid_o !== 1'b1 || {err_o, zero_o, data_o} !== e) begin
            n_fail++;
            $display("FAIL first_edge_after_reset: got valid=%b err/zero/data=%h, expected valid=1 %h",
                     valid_o, {err_o, zero_o, data_o}, e);
        end
    endtask

    task automatic test_add();
        logic [33:0] e;
        @(negedge clk);
        issue(3'd0, 32'd7, 32'd5);
        @(negedge clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        e = exp_q.pop_front();
        n_tests++;
        if (valid_o !== 1'b1 || {err_o, zero_o, data_o} !== e || data_o !== 32'd12) begin
            n_fail++;
            $display("FAIL add_7_5: got valid=%b err/zero/data=%h, expected valid=1 %h",
                     valid_o, {err_o, zero_o, data_o}, e);
        end
        @(negedge clk);
        n_tests++;
        if (valid_o !== 1'b0 || data_o !== 32'd12 || zero_o !== 1'b0) begin
            n_fail++;
            $display("FAIL add_hold: got valid=%b data=%h zero=%b, expected valid=0 data=0000000c zero=0",
                     valid_o, data_o, zero_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] e;
        logic [2:0]  op;
        @(negedge clk);
        issue(3'd1, 32'd5, 32'd5);
        // Sub/or pair followed by a random stream of single-cycle ops, one per cycle.
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (valid_o !== 1'b1 || {err_o, zero_o, data_o} !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got valid=%b err/zero/data=%h, expected valid=1 %h",
                         i, valid_o, {err_o, zero_o, data_o}, e);
            end
            if (i == 0) begin
                issue(3'd3, 32'h0000_00F0, 32'h0000_000F);
            end else if (i < 10) begin
                op = 3'($urandom_range(0, 7));
                if (op == 3'd4) op = 3'd6;
                issue(op, $urandom, (i == 5) ? 32'd0 : $urandom);
            end else begin
                drive(1'b0, 3'd0, 32'd0, 32'd0);
            end
        end
        @(negedge clk);
        n_tests++;
        if (valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_end: got valid=%b, expected 0", valid_o);
        end
    endtask

    task automatic test_mul();
        logic [33:0] e;
        logic [31:0] av[3];
        logic [31:0] bv[3];
        av[0] = 32'hFFFF_FFFF; bv[0] = 32'd3;
        av[1] = $urandom;      bv[1] = $urandom;
        av[2] = 32'h8000_0001; bv[2] = 32'hFFFF_FFFF;
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            issue(3'd4, av[p], bv[p]);
            for (int k = 1; k <= 32; k++) begin
                @(negedge clk);
                if (k == 1) drive(1'b0, 3'd0, 32'd0, 32'd0);
                n_tests++;
                if (busy_o !== 1'b1 || valid_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mul_busy[%0d] T+%0d: got busy=%b valid=%b, expected busy=1 valid=0",
                             p, k, busy_o, valid_o);
                end
            end
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (valid_o !== 1'b1 || busy_o !== 1'b0 || {err_o, zero_o, data_o} !== e) begin
                n_fail++;
                $display("FAIL mul_result[%0d]: got valid=%b busy=%b err/zero/data=%h, expected valid=1 busy=0 %h",
                         p, valid_o, busy_o, {err_o, zero_o, data_o}, e);
            end
            // A new op is accepted in the same cycle the multiply result appears.
            issue(3'd0, av[p], 32'd1);
            @(negedge clk);
            drive(1'b0, 3'd0, 32'd0, 32'd0);
            e = exp_q.pop_front();
            n_tests++;
            if (valid_o !== 1'b1 || {err_o, zero_o, data_o} !== e) begin
                n_fail++;
                $display("FAIL mul_followon[%0d]: got valid=%b err/zero/data=%h, expected valid=1 %h",
                         p, valid_o, {err_o, zero_o, data_o}, e);
            end
        end
    endtask

    task automatic test_mul_ignore();
        logic [33:0] e;
        int pulses;
        pulses = 0;
        @(negedge clk);
        issue(3'd4, 32'd0, 32'h1234);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) drive(1'b0, 3'd0, 32'd0, 32'd0);
            if (k == 5) drive(1'b1, 3'd0, 32'd7, 32'd7);
            if (k == 6) drive(1'b0, 3'd0, 32'd0, 32'd0);
            if (valid_o === 1'b1) begin
                pulses++;
                n_tests++;
                if (k != 33 || exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mul_ignore_pulse: got valid at T+%0d, expected only at T+33", k);
                end else begin
                    e = exp_q.pop_front();
                    if ({err_o, zero_o, data_o} !== e) begin
                        n_fail++;
                        $display("FAIL mul_ignore_result: got err/zero/data=%h, expected %h",
                                 {err_o, zero_o, data_o}, e);
                    end
                end
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL mul_ignore_count: got %0d valid pulses, expected 1", pulses);
        end
    endtask

    task automatic test_mul_reset();
        logic [33:0] e;
        int pulses;
        pulses = 0;
        @(negedge clk);
        drive(1'b1, 3'd4, 32'd12345, 32'd678);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) drive(1'b0, 3'd0, 32'd0, 32'd0);
        end
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        n_tests++;
        if ({data_o, zero_o, valid_o, busy_o, err_o} !== 36'd0) begin
            n_fail++;
            $display("FAIL mul_reset_async: got data=%h zero=%b valid=%b busy=%b err=%b, expected all 0",
                     data_o, zero_o, valid_o, busy_o, err_o);
        end
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_o === 1'b1 || busy_o === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL mul_reset_abort: got %0d cycles with valid/busy after release, expected 0", pulses);
        end
        issue(3'd0, 32'd1, 32'd1);
        @(negedge clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        e = exp_q.pop_front();
        n_tests++;
        if (valid_o !== 1'b1 || {err_o, zero_o, data_o} !== e || data_o !== 32'd2) begin
            n_fail++;
            $display("FAIL mul_reset_add: got valid=%b err/zero/data=%h, expected valid=1 %h",
                     valid_o, {err_o, zero_o, data_o}, e);
        end
    endtask

    task automatic test_illegal();
        logic [33:0] e;
        logic [2:0]  ops[3];
        ops[0] = 3'b111; ops[1] = 3'b101; ops[2] = 3'b110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            issue(ops[i], 32'h1234, 32'h5678);
            @(negedge clk);
            drive(1'b0, 3'd0, 32'd0, 32'd0);
            e = exp_q.pop_front();
            n_tests++;
            if (valid_o !== 1'b1 || {err_o, zero_o, data_o} !== e) begin
                n_fail++;
                $display("FAIL illegal_op[%b]: got valid=%b err/zero/data=%h, expected valid=1 %h",
                         ops[i], valid_o, {err_o, zero_o, data_o}, e);
            end
        end
        @(negedge clk);
        issue(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF);
        @(negedge clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        e = exp_q.pop_front();
        n_tests++;
        if (valid_o !== 1'b1 || {err_o, zero_o, data_o} !== e) begin
            n_fail++;
            $display("FAIL err_clear_and: got valid=%b err/zero/data=%h, expected valid=1 %h",
                     valid_o, {err_o, zero_o, data_o}, e);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_mul_ignore();
        test_mul_reset();
        test_illegal();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d outstanding results, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; the only supported value is 32.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 valid_i  input  1  operation issue strobe from the EX stage.
REQ-005 data1_i  input  32  operand A (rs).
REQ-006 data2_i  input  32  operand B (rt or sign-extended immediate).
REQ-007 ALUCtrl_i  input  3  op code from ALU control: 000 add, 001 sub, 010 and, 011 or, 100 mul; others illegal.
REQ-008 data_o  output  32  registered result.
REQ-009 zero_o  output  1  registered, high when data_o equals 0.
REQ-010 valid_o  output  1  one-cycle pulse; data_o/zero_o/err_o are new this cycle.
REQ-011 busy_o  output  1  multiply in progress; upstream stall request.
REQ-012 err_o  output  1  registered, high when the last completed op had an illegal code.

Function
REQ-013 The block SHALL have two states: IDLE and MUL; busy_o SHALL be high exactly when state is MUL.
REQ-014 Accept: valid_i high in IDLE at a rising edge SHALL capture the op; valid_i in MUL SHALL be ignored, with no state change and no later valid_o.
REQ-015 Single-cycle ops (000-011, illegal codes) accepted at edge E SHALL update data_o, zero_o, err_o and raise valid_o during the cycle following E; state stays IDLE.
REQ-016 add/sub SHALL be 32-bit two's-complement modulo 2^32 with no overflow flag; and/or SHALL be bitwise.
REQ-017 Illegal codes (101, 110, 111) SHALL produce data_o=0, zero_o=1, err_o=1; legal ops SHALL produce err_o=0.
REQ-018 Back-to-back single-cycle ops on consecutive cycles SHALL each produce valid_o on consecutive cycles.
REQ-019 mul accepted at edge E SHALL load multiplicand=data1_i, multiplier=data2_i, accumulator=0, count=0 and enter MUL.
REQ-020 Each MUL-state edge SHALL add the multiplicand to the accumulator when multiplier bit 0 is 1, shift the multiplicand left by 1, shift the multiplier right by 1, and increment count (5-bit).
REQ-021 At the 32nd MUL-state edge (count 31 -> wrap) the block SHALL write the accumulator's final low 32 bits to data_o, update zero_o, set err_o=0, pulse valid_o, and return to IDLE.
REQ-022 mul latency SHALL be fixed: issue cycle T, busy_o high in cycles T+1..T+32, valid_o high in cycle T+33; no early termination on zero operands.
REQ-023 mul result SHALL equal the low 32 bits of the product (identical for signed and unsigned operands).
REQ-024 A new op SHALL be accepted in cycle T+33 (state IDLE) concurrently with the mul valid_o pulse.
REQ-025 data_o, zero_o, err_o SHALL hold their last values between valid_o pulses; valid_o SHALL never be high for two cycles from one op.

Reset
REQ-026 rst_i low SHALL immediately force state=IDLE, count=0, accumulator=0, data_o=0, zero_o=0, valid_o=0, busy_o=0, err_o=0, independent of clk_i.
REQ-027 Reset during MUL SHALL abort the multiply; no valid_o SHALL be produced for it after release.
REQ-028 The first rising edge after rst_i returns high SHALL accept valid_i normally.

Verification
REQ-029 add 7+5 issued cycle T -> cycle T+1: valid_o=1, data_o=12, zero_o=0, err_o=0; T+2: valid_o=0, data_o still 12.
REQ-030 sub 5-5, then or 0xF0|0x0F on the next cycle -> consecutive valid_o pulses: data_o=0/zero_o=1, then data_o=0xFF/zero_o=0.
REQ-031 mul 0xFFFFFFFF*3 at T -> busy_o=1 in cycles T+1..T+32; cycle T+33: valid_o=1, data_o=0xFFFFFFFD, busy_o=0.
REQ-032 add issued at T+5 during a mul -> ignored; exactly one valid_o, at T+33, carrying the mul result.
REQ-033 rst_i low during cycle T+10 of a mul -> all outputs 0 at once; no valid_o after release; next add 1+1 -> data_o=2 one cycle later.
REQ-034 ALUCtrl_i=111 with operands 0x1234/0x5678 -> next cycle: valid_o=1, data_o=0, zero_o=1, err_o=1.
